// File: rtl/dlx_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : dlx_fetch_unit
//  Brief    : DLX instruction fetch. Owns the PC, issues in-order word fetches,
//             buffers returned words with their PCs toward decode, and handles
//             redirects by squashing wrong-path slots and in-flight responses.
//  Revision : 1.0
// ============================================================================
module dlx_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int              c_CW    = $clog2(BUF_DEPTH + 1);
    localparam int              c_PW    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [c_CW-1:0] c_DEPTH = c_CW'(BUF_DEPTH);
    localparam logic [c_PW-1:0] c_LAST  = c_PW'(BUF_DEPTH - 1);

    logic [31:0]          r_fetch_pc;
    logic [31:0]          r_slot_pc   [BUF_DEPTH];
    logic [31:0]          r_slot_data [BUF_DEPTH];
    logic [BUF_DEPTH-1:0] r_slot_filled;
    logic [c_PW-1:0]      r_alloc_ptr;
    logic [c_PW-1:0]      r_fill_ptr;
    logic [c_PW-1:0]      r_head_ptr;
    logic [c_CW-1:0]      r_used;
    logic [c_CW-1:0]      r_pend;
    logic [c_CW-1:0]      r_drop_cnt;

    logic                 w_grant;
    logic                 w_fill;
    logic                 w_drop_rsp;
    logic                 w_pop;
    logic [c_CW-1:0]      w_redir_drop;
    logic                 w_unused;

    function automatic logic [c_PW-1:0] f_inc(input logic [c_PW-1:0] p);
        return (p == c_LAST) ? '0 : p + 1'b1;
    endfunction

    // Slots still awaiting data plus responses already marked for discard
    // never exceed BUF_DEPTH, so the sums below fit in c_CW bits.
    assign imem_req   = !reset && !redirect && ((r_used + r_drop_cnt) < c_DEPTH);
    assign imem_addr  = r_fetch_pc;
    assign w_grant    = imem_req && imem_gnt;
    assign w_drop_rsp = imem_rvalid && (r_drop_cnt != '0);
    assign w_fill     = imem_rvalid && (r_drop_cnt == '0) && (r_pend != '0);

    assign inst_valid = r_slot_filled[r_head_ptr];
    assign inst       = r_slot_data[r_head_ptr];
    assign inst_pc    = r_slot_pc[r_head_ptr];
    assign w_pop      = inst_valid && inst_ready;

    // Any response arriving in the redirect cycle is wrong-path: it consumes
    // one of the outstanding fetches instead of adding to the discard count.
    assign w_redir_drop = r_drop_cnt + r_pend
                        - c_CW'(imem_rvalid && ((r_drop_cnt != '0) || (r_pend != '0)));

    assign w_unused = ^redirect_pc[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_alloc_ptr   <= '0;
            r_fill_ptr    <= '0;
            r_head_ptr    <= '0;
            r_used        <= '0;
            r_pend        <= '0;
            r_drop_cnt    <= '0;
            r_slot_filled <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_slot_pc[i]   <= '0;
                r_slot_data[i] <= '0;
            end
        end else if (redirect) begin
            r_fetch_pc    <= {redirect_pc[31:2], 2'b00};
            r_alloc_ptr   <= '0;
            r_fill_ptr    <= '0;
            r_head_ptr    <= '0;
            r_used        <= '0;
            r_pend        <= '0;
            r_drop_cnt    <= w_redir_drop;
            r_slot_filled <= '0;
        end else begin
            if (w_grant) begin
                r_slot_pc[r_alloc_ptr] <= r_fetch_pc;
                r_alloc_ptr            <= f_inc(r_alloc_ptr);
                r_fetch_pc             <= r_fetch_pc + 32'd4;
            end
            if (w_fill) begin
                r_slot_data[r_fill_ptr]   <= imem_rdata;
                r_slot_filled[r_fill_ptr] <= 1'b1;
                r_fill_ptr                <= f_inc(r_fill_ptr);
            end
            if (w_pop) begin
                r_slot_filled[r_head_ptr] <= 1'b0;
                r_head_ptr                <= f_inc(r_head_ptr);
            end
            if (w_drop_rsp) begin
                r_drop_cnt <= r_drop_cnt - 1'b1;
            end
            r_used <= r_used + c_CW'(w_grant) - c_CW'(w_pop);
            r_pend <= r_pend + c_CW'(w_grant) - c_CW'(w_fill);
        end
    end

    // A response with nothing outstanding is a memory protocol violation.
    a_no_orphan_rsp : assert property (@(posedge clk) disable iff (reset)
        imem_rvalid |-> ((r_drop_cnt != '0) || (r_pend != '0)));

endmodule
`default_nettype wire

// File: tb/tb_dlx_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dlx_fetch_unit
//  Brief    : Directed bench for dlx_fetch_unit with an in-order memory model
//             and a scoreboard of expected {pc, inst} pairs toward decode.
//  Revision : 1.0
// ============================================================================
module tb_dlx_fetch_unit;

    localparam int          c_DEPTH    = 3;
    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    always #5 clk = ~clk;

    dlx_fetch_unit #(
        .RESET_PC  (c_RESET_PC),
        .BUF_DEPTH (c_DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;

    exp_t        exp_q[$];
    exp_t        sb_e;
    mreq_t       mem_q[$];
    logic [31:0] gaddr_q[$];
    int          cyc     = 0;
    int          lat     = 1;
    int          n_chk   = 0;
    int          n_fail  = 0;
    int          n_pop   = 0;
    int          n_grant = 0;
    int          t;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_stream(input logic [31:0] start, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            logic [31:0] a;
            a = start + 32'(4 * i);
            exp_q.push_back('{pc: a, data: mem_word(a)});
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(1);
        reset      = 1'b1;
        redirect   = 1'b0;
        inst_ready = 1'b1;
        imem_gnt   = 1'b1;
        exp_q.delete();
        step(2);
        reset = 1'b0;
        push_stream(c_RESET_PC, 64);
        n_pop   = 0;
        n_grant = 0;
        gaddr_q.delete();
    endtask

    // Memory response side: in order, at least `lat` cycles after the grant.
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
        #1;
        if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mem_q[0].addr);
            void'(mem_q.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
    end

    // Memory request side; the memory shares the core reset and squashes on it.
    initial forever begin
        @(negedge clk);
        if (reset) begin
            mem_q.delete();
        end else if (imem_req && imem_gnt) begin
            mem_q.push_back('{addr: imem_addr, due: cyc + lat});
            gaddr_q.push_back(imem_addr);
            n_grant++;
        end
    end

    // Decode-side monitor: every accepted instruction must be the next expected one.
    initial forever begin
        @(negedge clk);
        if (!reset && !redirect && inst_valid && inst_ready) begin
            n_pop++;
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_extra: got pc %h, expected no instruction", inst_pc);
            end else begin
                sb_e = exp_q.pop_front();
                chk("sb_pc", inst_pc, sb_e.pc);
                chk("sb_inst", inst, sb_e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, expected finish before 100000ns");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        step(2);
        sample();
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_addr", imem_addr, c_RESET_PC);
        chk("rst_valid", {31'b0, inst_valid}, 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_pc", inst_pc, 32'h0);

        // 1: streaming at latency 1, one instruction per cycle
        lat = 1;
        do_reset();
        sample();
        chk("t1_first_req", {31'b0, imem_req}, 32'h1);
        chk("t1_first_addr", imem_addr, c_RESET_PC);
        step(10);
        n_pop = 0;
        step(20);
        chk("t1_rate", n_pop, 32'd20);

        // 2: decode stalled, buffer fills and the head stays put
        do_reset();
        inst_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sample();
            if (i >= 4) begin
                chk("t2_hold_valid", {31'b0, inst_valid}, 32'h1);
                chk("t2_hold_pc", inst_pc, 32'h0);
                chk("t2_hold_inst", inst, mem_word(32'h0));
            end
            step(1);
        end
        sample();
        chk("t2_req_off", {31'b0, imem_req}, 32'h0);
        chk("t2_grants", n_grant, c_DEPTH);
        step(1);
        inst_ready = 1'b1;
        n_pop = 0;
        step(10);
        chk("t2_resume", {31'b0, n_pop >= 5}, 32'h1);

        // 3: latency 3, redirect with two fetches in flight
        lat = 3;
        do_reset();
        t = 0;
        sample();
        while (mem_q.size() < 2 && t < 20) begin
            step(1);
            sample();
            t++;
        end
        chk("t3_inflight", mem_q.size(), 32'd2);
        step(1);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        push_stream(32'h0000_0100, 64);
        step(1);
        redirect = 1'b0;
        sample();
        chk("t3_valid_after_redir", {31'b0, inst_valid}, 32'h0);
        n_pop = 0;
        step(15);
        chk("t3_pops", {31'b0, n_pop >= 5}, 32'h1);

        // 4: redirect coinciding with a response, then a second redirect
        lat = 2;
        do_reset();
        step(6);
        t = 0;
        while (!imem_rvalid && t < 10) begin
            step(1);
            t++;
        end
        chk("t4_wait_rvalid", {31'b0, t < 10}, 32'h1);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0080;
        exp_q.delete();
        gaddr_q.delete();
        step(1);
        redirect_pc = 32'h0000_0200;
        push_stream(32'h0000_0200, 64);
        step(1);
        redirect = 1'b0;
        n_pop = 0;
        step(12);
        chk("t4_pops", {31'b0, n_pop >= 4}, 32'h1);
        chk("t4_grant_cnt", {31'b0, gaddr_q.size() >= 1}, 32'h1);
        if (gaddr_q.size() >= 1) chk("t4_first_addr", gaddr_q[0], 32'h0000_0200);

        // 5: unaligned redirect target, held request, PC wrap
        lat = 1;
        do_reset();
        step(5);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        imem_gnt    = 1'b0;
        push_stream(32'h0000_0100, 64);
        step(1);
        redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("t5_req_held", {31'b0, imem_req}, 32'h1);
            chk("t5_addr_held", imem_addr, 32'h0000_0100);
            step(1);
        end
        imem_gnt = 1'b1;
        step(6);
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        push_stream(32'hFFFF_FFFC, 64);
        gaddr_q.delete();
        step(1);
        redirect = 1'b0;
        n_pop = 0;
        step(10);
        chk("t5_pops", {31'b0, n_pop >= 5}, 32'h1);
        chk("t5_grant_cnt", {31'b0, gaddr_q.size() >= 2}, 32'h1);
        if (gaddr_q.size() >= 2) begin
            chk("t5_wrap_a0", gaddr_q[0], 32'hFFFF_FFFC);
            chk("t5_wrap_a1", gaddr_q[1], 32'h0000_0000);
        end

        // 6: reset with fetches outstanding
        lat = 3;
        do_reset();
        step(8);
        t = 0;
        sample();
        while (mem_q.size() < 2 && t < 20) begin
            step(1);
            sample();
            t++;
        end
        chk("t6_inflight", {31'b0, mem_q.size() >= 2}, 32'h1);
        reset = 1'b1;
        exp_q.delete();
        sample();
        chk("t6_req", {31'b0, imem_req}, 32'h0);
        chk("t6_addr", imem_addr, c_RESET_PC);
        chk("t6_valid", {31'b0, inst_valid}, 32'h0);
        chk("t6_inst", inst, 32'h0);
        chk("t6_pc", inst_pc, 32'h0);
        step(1);
        reset = 1'b0;
        push_stream(c_RESET_PC, 64);
        n_pop = 0;
        sample();
        chk("t6_refetch_req", {31'b0, imem_req}, 32'h1);
        chk("t6_refetch_addr", imem_addr, c_RESET_PC);
        step(12);
        chk("t6_pops", {31'b0, n_pop >= 3}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
